// File: rtl/systolic_sequencer.sv
// Job sequencer for an output-stationary SIZE x SIZE systolic MAC array:
// accumulator clear, skewed operand feed, zero flush, then row-by-row result drain.

module systolic_skew_lane #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH*W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sr <= '0;
    else if (clr) sr <= '0;
    else          sr <= (DEPTH*W)'({sr, din});
  end

  assign dout = sr[DEPTH*W-1 -: W];
endmodule

module systolic_sequencer #(
  parameter int N     = 16,
  parameter int SIZE  = 4,
  parameter int K_MAX = 64,
  parameter int KW    = $clog2(K_MAX+1),
  parameter int AW    = $clog2(K_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  output logic                     busy,
  output logic                     done,
  output logic                     a_rd_en,
  output logic                     b_rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [SIZE*N-1:0]        a_rd_data,
  input  logic [SIZE*N-1:0]        b_rd_data,
  output logic                     arr_clr,
  output logic [SIZE*N-1:0]        arr_a,
  output logic [SIZE*N-1:0]        arr_b,
  input  logic [SIZE*SIZE*N-1:0]   arr_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(SIZE)-1:0]  res_row,
  output logic [SIZE*N-1:0]        res_data
);
  localparam int RW = $clog2(SIZE);
  localparam int CW = (KW > $clog2(2*SIZE)) ? KW : $clog2(2*SIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state;
  logic [KW-1:0] kl;
  logic [CW-1:0] cnt;
  logic [RW-1:0] row;
  logic          rd_vld;
  logic          feed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      kl     <= '0;
      cnt    <= '0;
      row    <= '0;
      rd_vld <= 1'b0;
    end else begin
      // Buffer data returns one cycle after the read; this flag qualifies it.
      rd_vld <= (state == S_FEED);
      case (state)
        S_IDLE: if (start) begin
          kl    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
          state <= S_CLEAR;
        end
        S_CLEAR: begin
          cnt   <= '0;
          row   <= '0;
          state <= (kl != '0) ? S_FEED : S_DRAIN;
        end
        S_FEED: if (cnt == CW'(kl) - CW'(1)) begin
          cnt   <= '0;
          state <= S_FLUSH;
        end else cnt <= cnt + CW'(1);
        // 2*SIZE cycles lets the last operand cross the array diagonal and accumulate.
        S_FLUSH: if (cnt == CW'(2*SIZE-1)) begin
          cnt   <= '0;
          state <= S_DRAIN;
        end else cnt <= cnt + CW'(1);
        S_DRAIN: if (res_ready) begin
          if (row == RW'(SIZE-1)) begin
            row   <= '0;
            state <= S_FIN;
          end else row <= row + RW'(1);
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign feed      = (state == S_FEED);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign arr_clr   = (state == S_CLEAR);
  assign a_rd_en   = feed;
  assign b_rd_en   = feed;
  assign rd_addr   = feed ? cnt[AW-1:0] : '0;
  assign res_valid = (state == S_DRAIN);
  assign res_row   = row;

  logic [SIZE-1:0][SIZE*N-1:0] c_rows;
  assign c_rows   = arr_c;
  assign res_data = res_valid ? c_rows[row] : '0;

  // Bubbles are forced to zero so the skew chains only ever carry real data or zeros.
  logic [SIZE-1:0][N-1:0] a_in, b_in, a_sk, b_sk;
  assign a_in = rd_vld ? a_rd_data : '0;
  assign b_in = rd_vld ? b_rd_data : '0;

  assign a_sk[0] = a_in[0];
  assign b_sk[0] = b_in[0];

  generate
    for (genvar i = 1; i < SIZE; i++) begin : g_lane
      logic [2*N-1:0] lane_out;
      systolic_skew_lane #(.W(2*N), .DEPTH(i)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .clr  (arr_clr),
        .din  ({b_in[i], a_in[i]}),
        .dout (lane_out)
      );
      assign a_sk[i] = lane_out[N-1:0];
      assign b_sk[i] = lane_out[2*N-1:N];
    end
  endgenerate

  assign arr_a = a_sk;
  assign arr_b = b_sk;
endmodule
